id_issue_latch: RTL and testbench

- Parametrised ID→EXE issue register: latches decoded bundles of LANES instructions into the EXE stage.
- Adds valid/ready handshaking, downstream stall, flush, and a configurable serialize (syscall / LL / SC) drain sequencer.
- Sits between decode/operand-fetch and EXE, and drives the fetch freeze request and the simulator SYS pulse.

---
 rtl/id_issue_latch.sv | 228 ++++++++++++++++++++++
 tb/tb_id_issue_latch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_latch.sv
// ID->EXE issue register with valid/ready, flush and a serialize drain sequencer (syscall / LL / SC).
// Optional macro ID_ISSUE_STATS_EN adds issue / bubble / serialize statistics counters.
module id_issue_latch #(
    parameter int unsigned LANES        = 1,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned BUBBLE_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*DATA_W-1:0]   in_instr,
    input  logic [LANES*DATA_W-1:0]   in_pc,
    input  logic [LANES*DATA_W-1:0]   in_opa,
    input  logic [LANES*DATA_W-1:0]   in_opb,
    input  logic [LANES*DATA_W-1:0]   in_memdata,
    input  logic [LANES*REG_W-1:0]    in_wreg,
    input  logic [LANES-1:0]          in_regwrite,
    input  logic [LANES*6-1:0]        in_alu_ctrl,
    input  logic [LANES-1:0]          in_memread,
    input  logic [LANES-1:0]          in_memwrite,
    input  logic [LANES*5-1:0]        in_shamt,
    input  logic [LANES-1:0]          in_serialize,
    input  logic [LANES-1:0]          in_sys_quiet,
    output logic [LANES-1:0]          in_take,
    input  logic                      out_ready,
    input  logic                      flush,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES*DATA_W-1:0]   out_instr,
    output logic [LANES*DATA_W-1:0]   out_pc,
    output logic [LANES*DATA_W-1:0]   out_opa,
    output logic [LANES*DATA_W-1:0]   out_opb,
    output logic [LANES*DATA_W-1:0]   out_memdata,
    output logic [LANES*REG_W-1:0]    out_wreg,
    output logic [LANES-1:0]          out_regwrite,
    output logic [LANES*6-1:0]        out_alu_ctrl,
    output logic [LANES-1:0]          out_memread,
    output logic [LANES-1:0]          out_memwrite,
    output logic [LANES*5-1:0]        out_shamt,
    output logic                      sys,
    output logic                      want_freeze
`ifdef ID_ISSUE_STATS_EN
    ,
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_bubbles,
    output logic [15:0]               stat_serial
`endif
);

    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        SIGNAL  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    quiet_q, quiet_d;
    logic                    sys_q, want_freeze_q;

    logic [LANES-1:0]        valid_q;
    logic [LANES*DATA_W-1:0] instr_q, pc_q, opa_q, opb_q, memdata_q;
    logic [LANES*REG_W-1:0]  wreg_q;
    logic [LANES-1:0]        regwrite_q, memread_q, memwrite_q;
    logic [LANES*6-1:0]      alu_ctrl_q;
    logic [LANES*5-1:0]      shamt_q;

    logic                    adv_c, idle_go_c, ser_go_c;
    logic [SEL_W-1:0]        sel_c;
    logic [LANES-1:0]        take_c;
    logic                    unused_quiet;

    // Only lane 0 can carry an accepted serialize, so the other quiet bits are never used.
    assign unused_quiet = ^in_sys_quiet;

    assign adv_c     = out_ready | ~|valid_q;
    assign idle_go_c = (state_q == IDLE) & adv_c & ~flush;
    assign ser_go_c  = idle_go_c & (sel_c == '0);

    // Lowest serializing lane bounds how many lanes are taken this cycle.
    always_comb begin
        sel_c  = SEL_W'(LANES);
        take_c = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (in_valid[i] & in_serialize[i]) sel_c = SEL_W'(i);
        end
        for (int i = 0; i < int'(LANES); i++) begin
            take_c[i] = idle_go_c & ((in_valid[i] & (SEL_W'(i) < sel_c)) |
                                     ((i == 0) & (sel_c == '0)));
        end
    end

    assign in_take = RESET ? take_c : '0;

    // Sequencer next state; the counter moves only on an advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quiet_d = quiet_q;
        case (state_q)
            IDLE: begin
                if (ser_go_c) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(BUBBLE_DEPTH - 1);
                    quiet_d = in_sys_quiet[0];
                end
            end
            DRAIN: begin
                if (adv_c) begin
                    if (cnt_q == '0) state_d = SIGNAL;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            SIGNAL:  state_d = RELEASE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            quiet_q       <= 1'b0;
            sys_q         <= 1'b0;
            want_freeze_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            quiet_q       <= quiet_d;
            sys_q         <= (state_d == SIGNAL) & ~quiet_d;
            want_freeze_q <= (state_d == DRAIN);
        end
    end

    // Issue register; a serialize keeps only instr/pc/alu_ctrl so MEM sees it without side effects.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q    <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            memdata_q  <= '0;
            wreg_q     <= '0;
            regwrite_q <= '0;
            alu_ctrl_q <= '0;
            memread_q  <= '0;
            memwrite_q <= '0;
            shamt_q    <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (idle_go_c) begin
            valid_q    <= take_c;
            instr_q    <= in_instr;
            pc_q       <= in_pc;
            opa_q      <= in_opa;
            opb_q      <= in_opb;
            memdata_q  <= in_memdata;
            wreg_q     <= in_wreg;
            alu_ctrl_q <= in_alu_ctrl;
            memread_q  <= in_memread;
            memwrite_q <= in_memwrite;
            shamt_q    <= in_shamt;
            for (int i = 0; i < int'(LANES); i++) begin
                regwrite_q[i] <= in_regwrite[i] & (in_wreg[i*REG_W +: REG_W] != '0);
            end
            if (ser_go_c) begin
                opa_q[0 +: DATA_W]     <= '0;
                opb_q[0 +: DATA_W]     <= '0;
                memdata_q[0 +: DATA_W] <= '0;
                wreg_q[0 +: REG_W]     <= '0;
                regwrite_q[0]          <= 1'b0;
                memread_q[0]           <= 1'b0;
                memwrite_q[0]          <= 1'b0;
                shamt_q[0 +: 5]        <= '0;
            end
        end else if ((state_q != IDLE) && adv_c) begin
            valid_q <= '0;
        end
    end

    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_pc       = pc_q;
    assign out_opa      = opa_q;
    assign out_opb      = opb_q;
    assign out_memdata  = memdata_q;
    assign out_wreg     = wreg_q;
    assign out_regwrite = regwrite_q;
    assign out_alu_ctrl = alu_ctrl_q;
    assign out_memread  = memread_q;
    assign out_memwrite = memwrite_q;
    assign out_shamt    = shamt_q;
    assign sys          = sys_q;
    assign want_freeze  = want_freeze_q;

`ifdef ID_ISSUE_STATS_EN
    logic [31:0] issued_q, bubbles_q, issued_inc_c;
    logic [15:0] serial_q;

    always_comb begin
        issued_inc_c = '0;
        for (int i = 0; i < int'(LANES); i++) issued_inc_c = issued_inc_c + 32'(take_c[i]);
    end

    // Counters wrap naturally at their width.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            issued_q  <= '0;
            bubbles_q <= '0;
            serial_q  <= '0;
        end else begin
            if (idle_go_c) issued_q <= issued_q + issued_inc_c;
            if ((state_q == DRAIN) && adv_c) bubbles_q <= bubbles_q + 32'd1;
            if (ser_go_c) serial_q <= serial_q + 16'd1;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_bubbles = bubbles_q;
    assign stat_serial  = serial_q;
`endif

endmodule

// File: tb/tb_id_issue_latch.sv
// Directed self-checking bench for id_issue_latch with LANES=2, BUBBLE_DEPTH=4.
module tb_id_issue_latch;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [LANES-1:0]        in_valid, in_regwrite, in_memread, in_memwrite, in_serialize, in_sys_quiet;
    logic [LANES*DATA_W-1:0] in_instr, in_pc, in_opa, in_opb, in_memdata;
    logic [LANES*REG_W-1:0]  in_wreg;
    logic [LANES*6-1:0]      in_alu_ctrl;
    logic [LANES*5-1:0]      in_shamt;
    logic [LANES-1:0]        in_take;
    logic                    out_ready, flush;
    logic [LANES-1:0]        out_valid, out_regwrite, out_memread, out_memwrite;
    logic [LANES*DATA_W-1:0] out_instr, out_pc, out_opa, out_opb, out_memdata;
    logic [LANES*REG_W-1:0]  out_wreg;
    logic [LANES*6-1:0]      out_alu_ctrl;
    logic [LANES*5-1:0]      out_shamt;
    logic                    sys, want_freeze;
`ifdef ID_ISSUE_STATS_EN
    logic [31:0]             stat_issued, stat_bubbles;
    logic [15:0]             stat_serial;
`endif

    int errors = 0;
    int checks = 0;

    id_issue_latch #(.LANES(LANES), .DATA_W(DATA_W), .REG_W(REG_W), .BUBBLE_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_opa(in_opa), .in_opb(in_opb),
        .in_memdata(in_memdata), .in_wreg(in_wreg), .in_regwrite(in_regwrite),
        .in_alu_ctrl(in_alu_ctrl), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_shamt(in_shamt), .in_serialize(in_serialize), .in_sys_quiet(in_sys_quiet),
        .in_take(in_take), .out_ready(out_ready), .flush(flush),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_opa(out_opa),
        .out_opb(out_opb), .out_memdata(out_memdata), .out_wreg(out_wreg),
        .out_regwrite(out_regwrite), .out_alu_ctrl(out_alu_ctrl), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_shamt(out_shamt), .sys(sys), .want_freeze(want_freeze)
`ifdef ID_ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_bubbles(stat_bubbles), .stat_serial(stat_serial)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        in_valid = '0; in_regwrite = '0; in_memread = '0; in_memwrite = '0;
        in_serialize = '0; in_sys_quiet = '0;
        in_instr = '0; in_pc = '0; in_opa = '0; in_opb = '0; in_memdata = '0;
        in_wreg = '0; in_alu_ctrl = '0; in_shamt = '0;
    endtask

    // Present one valid instruction on lane l; serializes also carry a store flag to prove it is stripped.
    task automatic put(input int l, input logic [31:0] instr, input logic [4:0] wreg,
                       input logic [5:0] alu, input logic ser, input logic quiet);
        in_valid[l]              = 1'b1;
        in_instr[l*32 +: 32]     = instr;
        in_pc[l*32 +: 32]        = 32'h1000 + 32'(l * 4);
        in_opa[l*32 +: 32]       = instr ^ 32'h55;
        in_opb[l*32 +: 32]       = 32'h77;
        in_memdata[l*32 +: 32]   = 32'h99;
        in_wreg[l*5 +: 5]        = wreg;
        in_regwrite[l]           = 1'b1;
        in_alu_ctrl[l*6 +: 6]    = alu;
        in_shamt[l*5 +: 5]       = 5'd3;
        in_memwrite[l]           = ser;
        in_serialize[l]          = ser;
        in_sys_quiet[l]          = quiet;
    endtask

    // Called one cycle after the serialize issued: 3 bubbles, SIGNAL, then RELEASE.
    task automatic drain(input logic exp_sys);
        for (int b = 0; b < 3; b++) begin
            step();
            chk("bub_valid", 64'(out_valid), 64'd0);
            chk("bub_freeze", 64'(want_freeze), 64'd1);
            chk("bub_sys", 64'(sys), 64'd0);
            chk("bub_take", 64'(in_take), 64'd0);
        end
        step();
        chk("sig_sys", 64'(sys), 64'(exp_sys));
        chk("sig_freeze", 64'(want_freeze), 64'd0);
        chk("sig_take", 64'(in_take), 64'd0);
        step();
        chk("rel_sys", 64'(sys), 64'd0);
        chk("rel_freeze", 64'(want_freeze), 64'd0);
        chk("rel_take", 64'(in_take), 64'd0);
    endtask

    initial begin
        RESET = 1'b0; out_ready = 1'b1; flush = 1'b0;
        clr();
        put(0, 32'h00221820, 5'd3, 6'h20, 1'b0, 1'b0);
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_take", 64'(in_take), 64'd0);
        chk("rst_sys", 64'(sys), 64'd0);
        chk("rst_freeze", 64'(want_freeze), 64'd0);
        #10 RESET = 1'b1;
        step();
        clr();

        // Two-lane bundle, then a wreg=0 write suppression.
        put(0, 32'h00221820, 5'd3, 6'h20, 1'b0, 1'b0);
        put(1, 32'h00432022, 5'd4, 6'h22, 1'b0, 1'b0);
        #1 chk("pair_take", 64'(in_take), 64'h3);
        step();
        chk("pair_valid", 64'(out_valid), 64'h3);
        chk("pair_wreg", 64'(out_wreg), 64'({5'd4, 5'd3}));
        chk("pair_regw", 64'(out_regwrite), 64'h3);
        chk("pair_opa1", 64'(out_opa[63:32]), 64'(32'h00432022 ^ 32'h55));
        clr();
        put(0, 32'h00000020, 5'd0, 6'h20, 1'b0, 1'b0);
        #1 chk("r0_take", 64'(in_take), 64'h1);
        step();
        chk("r0_valid", 64'(out_valid), 64'h1);
        chk("r0_regw", 64'(out_regwrite), 64'h0);

        // Stall holds, flush overrides the stall.
        out_ready = 1'b0;
        clr();
        put(0, 32'h11111111, 5'd9, 6'h01, 1'b0, 1'b0);
        #1 chk("stall_take", 64'(in_take), 64'd0);
        step();
        chk("stall_valid", 64'(out_valid), 64'h1);
        chk("stall_wreg", 64'(out_wreg[4:0]), 64'd0);
        chk("stall_instr", 64'(out_instr[31:0]), 64'h20);
        flush = 1'b1;
        #1 chk("flush_take", 64'(in_take), 64'd0);
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        clr();

        // Syscall in lane 0 with a normal lane 1 behind it.
        put(0, 32'h0000000c, 5'd2, 6'h2a, 1'b1, 1'b0);
        put(1, 32'h00432022, 5'd4, 6'h22, 1'b0, 1'b0);
        #1 chk("sc_take", 64'(in_take), 64'h1);
        step();
        chk("sc_valid", 64'(out_valid), 64'h1);
        chk("sc_instr", 64'(out_instr[31:0]), 64'hc);
        chk("sc_alu", 64'(out_alu_ctrl[5:0]), 64'h2a);
        chk("sc_pc", 64'(out_pc[31:0]), 64'h1000);
        chk("sc_opa", 64'(out_opa[31:0]), 64'd0);
        chk("sc_memdata", 64'(out_memdata[31:0]), 64'd0);
        chk("sc_wreg", 64'(out_wreg[4:0]), 64'd0);
        chk("sc_memw", 64'(out_memwrite[0]), 64'd0);
        chk("sc_freeze", 64'(want_freeze), 64'd1);
        chk("sc_sys", 64'(sys), 64'd0);
        clr();
        put(0, 32'h00221820, 5'd3, 6'h20, 1'b0, 1'b0);
        put(1, 32'h00432022, 5'd4, 6'h22, 1'b0, 1'b0);
        drain(1'b1);
        step();
        chk("idle_take", 64'(in_take), 64'h3);
        clr();
        step();

        // LL: same sequence, no SYS pulse.
        put(0, 32'hc0000000, 5'd6, 6'h11, 1'b1, 1'b1);
        step();
        chk("ll_valid", 64'(out_valid), 64'h1);
        chk("ll_freeze", 64'(want_freeze), 64'd1);
        clr();
        drain(1'b0);
        step();

        // Serialize in lane 1 is held back and re-presented in lane 0.
        put(0, 32'h00a52820, 5'd5, 6'h20, 1'b0, 1'b0);
        put(1, 32'h0000000c, 5'd0, 6'h2a, 1'b1, 1'b0);
        #1 chk("l1_take", 64'(in_take), 64'h1);
        step();
        chk("l1_valid", 64'(out_valid), 64'h1);
        chk("l1_wreg", 64'(out_wreg[4:0]), 64'd5);
        chk("l1_freeze", 64'(want_freeze), 64'd0);
        clr();
        put(0, 32'h0000000c, 5'd0, 6'h2a, 1'b1, 1'b0);
        #1 chk("l1re_take", 64'(in_take), 64'h1);
        step();
        chk("l1re_freeze", 64'(want_freeze), 64'd1);
        chk("l1re_instr", 64'(out_instr[31:0]), 64'hc);
        clr();
        drain(1'b1);
        step();

        // Stall on the issued serialize, then flush; bubble count unchanged afterwards.
        put(0, 32'h0000000c, 5'd0, 6'h2a, 1'b1, 1'b0);
        step();
        clr();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("dst_valid", 64'(out_valid), 64'h1);
            chk("dst_freeze", 64'(want_freeze), 64'd1);
            chk("dst_sys", 64'(sys), 64'd0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("dfl_valid", 64'(out_valid), 64'd0);
        chk("dfl_freeze", 64'(want_freeze), 64'd1);
        chk("dfl_instr", 64'(out_instr[31:0]), 64'hc);
        drain(1'b1);
        step();
        chk("dfl_after_sys", 64'(sys), 64'd0);
        out_ready = 1'b1;

        // Reset with the counter at 2, then a fresh full sequence.
        put(0, 32'h0000000c, 5'd0, 6'h2a, 1'b1, 1'b0);
        step();
        clr();
        step();
        put(0, 32'h00221820, 5'd3, 6'h20, 1'b0, 1'b0);
        #1 RESET = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_instr", 64'(out_instr[31:0]), 64'd0);
        chk("mrst_freeze", 64'(want_freeze), 64'd0);
        chk("mrst_take", 64'(in_take), 64'd0);
        RESET = 1'b1;
        clr();
        put(0, 32'h0000000c, 5'd0, 6'h2a, 1'b1, 1'b0);
        #1 chk("mrst_sc_take", 64'(in_take), 64'h1);
        step();
        chk("mrst_sc_freeze", 64'(want_freeze), 64'd1);
        clr();
        drain(1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
